upcount_load_sequencer: RTL and testbench

//  Sequencing controller for the 4-bit loadable up-counter datapath. On a start

---
 rtl/upcount_load_sequencer.sv | 102 ++++++++++
 tb/tb_upcount_load_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/upcount_load_sequencer.sv
// rtl/upcount_load_sequencer.sv - load/increment sequencer for a loadable up-counter
// Define AUTO_RELOAD_EN to make DONE restart the same sequence instead of returning to IDLE.
module upcount_load_sequencer #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] LOAD_VAL = WIDTH'(4'b0100)
) (
    input  logic             i_clk,
    input  logic             i_clear,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_hold,
    input  logic [WIDTH-1:0] i_ld_val,
    input  logic [WIDTH-1:0] i_term,
    input  logic [WIDTH-1:0] i_ctr_q,
    output logic             o_ctr_load,
    output logic             o_ctr_inc,
    output logic [WIDTH-1:0] o_ctr_din,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_din;
    logic [WIDTH-1:0] r_term;
    logic             r_load;
    logic             r_busy;
    logic             r_done;
    logic             w_at_term;

    assign w_at_term = (i_ctr_q == r_term);

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_state <= IDLE;
            r_din   <= LOAD_VAL;
            r_term  <= '0;
            r_load  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_load <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_din   <= i_ld_val;
                        r_term  <= i_term;
                        r_state <= LOAD;
                        r_load  <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (i_abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // Terminal compare wins over hold; abort wins over both.
                    if (i_abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_at_term) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
`ifdef AUTO_RELOAD_EN
                    r_state <= LOAD;
                    r_load  <= 1'b1;
`else
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
`endif
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Strobes to the counter are masked in the abort cycle so it never moves on a cancel.
    assign o_ctr_load = r_load & ~i_abort;
    assign o_ctr_inc  = (r_state == RUN) & ~i_hold & ~i_abort & ~w_at_term;
    assign o_ctr_din  = r_din;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_upcount_load_sequencer.sv
// tb/tb_upcount_load_sequencer.sv - scoreboard bench for upcount_load_sequencer
module tb_upcount_load_sequencer;

    logic       clk = 1'b0;
    logic       clear, start, abort, hold;
    logic [3:0] ld_val, term, ctr_q, ctr_din;
    logic       ctr_load, ctr_inc, busy, done;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    logic [3:0] exp_din;

    always #5 clk = ~clk;

    // Environment: the loadable up-counter the sequencer drives.
    always_ff @(posedge clk) begin
        if (ctr_load)
            ctr_q <= ctr_din;
        else if (ctr_inc)
            ctr_q <= ctr_q + 4'd1;
    end

    upcount_load_sequencer dut (
        .i_clk      (clk),
        .i_clear    (clear),
        .i_start    (start),
        .i_abort    (abort),
        .i_hold     (hold),
        .i_ld_val   (ld_val),
        .i_term     (term),
        .i_ctr_q    (ctr_q),
        .o_ctr_load (ctr_load),
        .o_ctr_inc  (ctr_inc),
        .o_ctr_din  (ctr_din),
        .o_busy     (busy),
        .o_done     (done)
    );

    task automatic cyc(input string tag, input logic l, input logic i, input logic b, input logic d);
        logic [7:0] e;
        logic [7:0] o;
        sb.push_back({l, i, b, d, exp_din});
        @(negedge clk);
        o = {ctr_load, ctr_inc, busy, done, ctr_din};
        e = sb.pop_front();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b (load,inc,busy,done,din)", tag, o, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input string nm, input logic [3:0] ld, input logic [3:0] tm,
                           input int hold_at, input int hold_len, input int abort_at,
                           input int bs_at, input int reloads);
        logic [3:0] diff;
        int         n;
        int         rem;
        int         c;
        diff   = tm - ld;
        n      = int'(diff);
        c      = 0;
        start  = 1'b1;
        ld_val = ld;
        term   = tm;
        cyc($sformatf("%s_c%0d", nm, c), 1'b0, 1'b0, 1'b0, 1'b0);
        start   = 1'b0;
        exp_din = ld;
        c++;
        for (int p = 0; p <= reloads; p++) begin
            cyc($sformatf("%s_c%0d", nm, c), 1'b1, 1'b0, 1'b1, 1'b0);
            c++;
            rem = n;
            while (1) begin
                hold   = (c >= hold_at) && (c < hold_at + hold_len);
                abort  = (c == abort_at);
                start  = (c == bs_at);
                ld_val = (c == bs_at) ? ~ld : ld;
                if (abort) begin
                    cyc($sformatf("%s_c%0d", nm, c), 1'b0, 1'b0, 1'b1, 1'b0);
                    abort = 1'b0;
                    hold  = 1'b0;
                    start = 1'b0;
                    c++;
                    cyc($sformatf("%s_c%0d", nm, c), 1'b0, 1'b0, 1'b0, 1'b0);
                    return;
                end
                if (rem == 0) begin
                    cyc($sformatf("%s_c%0d", nm, c), 1'b0, 1'b0, 1'b1, 1'b0);
                    c++;
                    break;
                end
                if (hold) begin
                    cyc($sformatf("%s_c%0d", nm, c), 1'b0, 1'b0, 1'b1, 1'b0);
                end else begin
                    cyc($sformatf("%s_c%0d", nm, c), 1'b0, 1'b1, 1'b1, 1'b0);
                    rem--;
                end
                c++;
            end
            hold   = 1'b0;
            start  = 1'b0;
            ld_val = ld;
            cyc($sformatf("%s_c%0d", nm, c), 1'b0, 1'b0, 1'b1, 1'b1);
            c++;
        end
        cyc($sformatf("%s_c%0d", nm, c), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear   = 1'b1;
        start   = 1'b1;
        abort   = 1'b0;
        hold    = 1'b0;
        ld_val  = 4'd9;
        term    = 4'd3;
        exp_din = 4'b0100;
        @(posedge clk);
        #1;
        cyc("rst0", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("rst1", 1'b0, 1'b0, 1'b0, 1'b0);
        clear = 1'b0;
        start = 1'b0;
        cyc("rst_start_dropped", 1'b0, 1'b0, 1'b0, 1'b0);

        abort = 1'b1;
        cyc("abort_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        abort = 1'b0;

`ifdef AUTO_RELOAD_EN
        run_seq("t6", 4'd4, 4'd6, -1, 0, 12, -1, 2);
        cyc("t6_stay_idle", 1'b0, 1'b0, 1'b0, 1'b0);
`else
        run_seq("t2", 4'd4, 4'd9, -1, 0, -1, -1, 0);
        run_seq("t3", 4'd14, 4'd1, -1, 0, -1, -1, 0);
        run_seq("t4", 4'd7, 4'd7, -1, 0, -1, -1, 0);
        run_seq("t4h", 4'd4, 4'd9, 3, 2, -1, -1, 0);
        run_seq("t5a", 4'd4, 4'd9, -1, 0, 4, -1, 0);
        run_seq("t5b", 4'd3, 4'd8, -1, 0, -1, 3, 0);

        start  = 1'b1;
        ld_val = 4'd2;
        term   = 4'd9;
        cyc("clr_c0", 1'b0, 1'b0, 1'b0, 1'b0);
        start   = 1'b0;
        exp_din = 4'd2;
        cyc("clr_c1", 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("clr_c2", 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("clr_c3", 1'b0, 1'b1, 1'b1, 1'b0);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear   = 1'b0;
        exp_din = 4'b0100;
        cyc("clr_after0", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("clr_after1", 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
